// File: rtl/mem_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_dma_pkg
// Purpose  : Shared types and constants for the mem_dma memory-port master.
// Revision : 1.0  initial release
// ============================================================================
package mem_dma_pkg;

    // Controller states; the width is fixed so encodings stay stable
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } dma_state_t;

    // Operation mode as latched from the mode input at start
    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_dma.sv
`default_nettype none
// ============================================================================
// Module   : mem_dma
// Purpose  : Memory-port master that copies LEN words SRC->DST or fills DST
//            with a constant, one word per memory cycle. The memory writes
//            st_data to ram[addr] on every edge, so the bus is parked at the
//            hardwired-zero address when idle and reads echo ld_data back.
// Revision : 1.0  initial release
// ============================================================================
module mem_dma #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] fill_val,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdat,
    input  logic [DW-1:0] mem_rdat
);

    import mem_dma_pkg::*;

    dma_state_t    r_state;
    dma_state_t    w_state_nxt;
    logic          r_mode;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [LW-1:0] r_cnt;
    logic [DW-1:0] r_fill;
    logic [DW-1:0] r_buf;
    logic          r_busy;
    logic          r_done;
    logic          r_aborted;

    assign busy    = r_busy;
    assign done    = r_done;
    assign aborted = r_aborted;

    // Next-state decode and the memory bus drive for the current state
    always_comb begin
        w_state_nxt = r_state;
        mem_addr    = '0;
        mem_wdat    = '0;
        case (r_state)
            IDLE: begin
                // abort in the same cycle as start suppresses the request
                if (start && !abort) begin
                    if (len == '0)
                        w_state_nxt = FIN;
                    else if (mode == MODE_FILL)
                        w_state_nxt = WRITE;
                    else
                        w_state_nxt = READ;
                end
            end
            READ: begin
                // echo the read data so the implicit memory write is harmless
                mem_addr    = r_src;
                mem_wdat    = mem_rdat;
                w_state_nxt = abort ? FIN : WRITE;
            end
            WRITE: begin
                mem_addr = r_dst;
                mem_wdat = (r_mode == MODE_FILL) ? r_fill : r_buf;
                if (abort || (r_cnt == LW'(1)))
                    w_state_nxt = FIN;
                else if (r_mode == MODE_FILL)
                    w_state_nxt = WRITE;
                else
                    w_state_nxt = READ;
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, operand latches, pointers, counter and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mode    <= MODE_COPY;
            r_src     <= '0;
            r_dst     <= '0;
            r_cnt     <= '0;
            r_fill    <= '0;
            r_buf     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_done    <= (w_state_nxt == FIN);
            r_aborted <= abort && ((r_state == READ) || (r_state == WRITE));
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_mode <= mode;
                        r_src  <= src;
                        r_dst  <= dst;
                        r_cnt  <= len;
                        r_fill <= fill_val;
                    end
                end
                READ: begin
                    r_buf <= mem_rdat;
                end
                WRITE: begin
                    // pointers wrap naturally at the top of the address space
                    r_dst <= r_dst + AW'(1);
                    if (r_mode == MODE_COPY)
                        r_src <= r_src + AW'(1);
                    // only reached with r_cnt >= 1, so this cannot underflow
                    r_cnt <= r_cnt - LW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_dma
// Purpose  : Self-checking bench for mem_dma with a 64Kx16 memory model and a
//            transaction-level reference that expands each operation into the
//            expected per-cycle bus trace.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] src = '0;
    logic [15:0] dst = '0;
    logic [15:0] len = '0;
    logic [15:0] fill_val = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdat;
    logic [15:0] mem_rdat;

    logic        poke_en = 1'b0;
    logic [15:0] poke_addr = '0;
    logic [15:0] poke_val = '0;

    logic [15:0] ram  [0:65535];
    logic [15:0] mram [0:65535];

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        ab;
        logic [15:0] addr;
        logic [15:0] wdat;
        logic        wchk;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_dma #(.AW(16), .DW(16), .LW(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .fill_val (fill_val),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .mem_addr (mem_addr),
        .mem_wdat (mem_wdat),
        .mem_rdat (mem_rdat)
    );

    // Single-port memory: combinational read, write every edge, address 0 hardwired
    assign mem_rdat = (mem_addr == 16'h0) ? 16'h0 : ram[mem_addr];

    always @(posedge clk) begin
        if (poke_en)
            ram[poke_addr] <= poke_val;
        else if (mem_addr != 16'h0)
            ram[mem_addr] <= mem_wdat;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // Per-cycle compare of the bus and status outputs against the expected trace
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (exp_q.size() > 0)
                e = exp_q.pop_front();
            else
                e = '{busy: 1'b0, done: 1'b0, ab: 1'b0, addr: 16'h0, wdat: 16'h0, wchk: 1'b1};
            chk("cyc_busy", {31'b0, busy}, {31'b0, e.busy});
            chk("cyc_done", {31'b0, done}, {31'b0, e.done});
            chk("cyc_aborted", {31'b0, aborted}, {31'b0, e.ab});
            chk("cyc_addr", {16'b0, mem_addr}, {16'b0, e.addr});
            if (e.wchk)
                chk("cyc_wdat", {16'b0, mem_wdat}, {16'b0, e.wdat});
        end
    end

    task automatic poke(input logic [15:0] a, input logic [15:0] v);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_val  = v;
        mram[a]   = v;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic poke_range(input logic [15:0] base, input int n, input logic [15:0] v);
        for (int i = 0; i < n; i++)
            poke(base + 16'(i), v + 16'(i));
    endtask

    // Expand one operation into its word-by-word bus trace; keep<0 means run to
    // completion, otherwise only the first keep cycles happen (abort or reset)
    task automatic push_op(input logic m, input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] l, input logic [15:0] f,
                           input int keep, input bit add_fin);
        int          idx = 0;
        logic [15:0] ps = s;
        logic [15:0] pd = d;
        logic [15:0] v;
        for (int i = 0; i < int'(l); i++) begin
            if (m == 1'b0) begin
                if (!(keep < 0 || idx < keep)) break;
                v = (ps == 16'h0) ? 16'h0 : mram[ps];
                exp_q.push_back('{busy: 1'b1, done: 1'b0, ab: 1'b0, addr: ps, wdat: v, wchk: 1'b1});
                idx++;
            end else begin
                v = f;
            end
            if (!(keep < 0 || idx < keep)) break;
            exp_q.push_back('{busy: 1'b1, done: 1'b0, ab: 1'b0, addr: pd, wdat: v, wchk: 1'b1});
            if (pd != 16'h0) mram[pd] = v;
            idx++;
            ps = ps + 16'd1;
            pd = pd + 16'd1;
        end
        if (keep < 0 || add_fin)
            exp_q.push_back('{busy: 1'b1, done: 1'b1, ab: add_fin, addr: 16'h0, wdat: 16'h0, wchk: 1'b0});
    endtask

    task automatic start_op(input logic m, input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] l, input logic [15:0] f,
                            input int keep, input bit add_fin);
        @(posedge clk);
        #1;
        start = 1'b1; mode = m; src = s; dst = d; len = l; fill_val = f;
        @(posedge clk);
        #1 start = 1'b0;
        push_op(m, s, d, l, f, keep, add_fin);
    endtask

    // Count cycles from the current point until done is seen (bounded)
    task automatic wait_done(input int expn, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        chk(nm, 32'(n), 32'(expn));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mram[i] = 16'h0;

        // reset state
        #3;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_aborted", {31'b0, aborted}, 32'h0);
        chk("rst_addr", {16'b0, mem_addr}, 32'h0);
        chk("rst_wdat", {16'b0, mem_wdat}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // preload
        poke(16'h0100, 16'h00A1); poke(16'h0101, 16'h00B2);
        poke(16'h0102, 16'h00C3); poke(16'h0103, 16'h00D4);
        poke_range(16'h0200, 4, 16'hFF00);
        poke_range(16'h0300, 4, 16'h3030);
        poke_range(16'h0400, 8, 16'h1000);
        poke_range(16'h0500, 8, 16'hDE00);
        poke_range(16'h0600, 4, 16'h6000);
        poke(16'h0700, 16'h5555);
        poke_range(16'h0800, 2, 16'h7777);
        poke_range(16'h0900, 3, 16'h9000);
        poke(16'hFFFE, 16'h0000); poke(16'hFFFF, 16'h0000);

        // 1: copy 4 words
        start_op(1'b0, 16'h0100, 16'h0200, 16'd4, 16'h0, -1, 1'b0);
        wait_done(9, "copy_done_cycle");
        @(negedge clk);
        chk("copy_dst0", {16'b0, ram[16'h0200]}, 32'h00A1);
        chk("copy_dst3", {16'b0, ram[16'h0203]}, 32'h00D4);
        chk("copy_src2", {16'b0, ram[16'h0102]}, 32'h00C3);

        // 2: fill 3 words
        start_op(1'b1, 16'h0, 16'h0300, 16'd3, 16'hBEEF, -1, 1'b0);
        wait_done(4, "fill_done_cycle");
        @(negedge clk);
        chk("fill_dst2", {16'b0, ram[16'h0302]}, 32'hBEEF);
        chk("fill_after", {16'b0, ram[16'h0303]}, 32'h3033);

        // 3: zero length
        start_op(1'b0, 16'h0100, 16'h0200, 16'd0, 16'h0, -1, 1'b0);
        wait_done(1, "len0_done_cycle");

        // 4: fill across the top of the address space
        start_op(1'b1, 16'h0, 16'hFFFE, 16'd3, 16'h1234, -1, 1'b0);
        wait_done(4, "wrap_done_cycle");
        @(negedge clk);
        chk("wrap_fffe", {16'b0, ram[16'hFFFE]}, 32'h1234);
        chk("wrap_ffff", {16'b0, ram[16'hFFFF]}, 32'h1234);

        // 5: abort during the third write of an 8-word copy
        start_op(1'b0, 16'h0400, 16'h0500, 16'd8, 16'h0, 6, 1'b1);
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_done(1, "abort_done_cycle");
        chk("abort_flag", {31'b0, aborted}, 32'h1);
        @(negedge clk);
        chk("abort_busy_after", {31'b0, busy}, 32'h0);
        chk("abort_dst2", {16'b0, ram[16'h0502]}, 32'h1002);
        chk("abort_dst3", {16'b0, ram[16'h0503]}, 32'hDE03);

        // start while busy is ignored
        start_op(1'b1, 16'h0, 16'h0600, 16'd3, 16'h6666, -1, 1'b0);
        start = 1'b1; mode = 1'b1; dst = 16'h0700; len = 16'd2; fill_val = 16'hAAAA;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(3, "busy_start_done_cycle");
        @(negedge clk);
        chk("busy_start_ignored", {16'b0, ram[16'h0700]}, 32'h5555);

        // start together with abort in idle does nothing
        @(posedge clk);
        #1 start = 1'b1; abort = 1'b1; mode = 1'b1; dst = 16'h0700; len = 16'd2;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_abort_idle", {31'b0, busy}, 32'h0);

        // 6: reset in the middle of a copy, then a normal fill
        start_op(1'b0, 16'h0100, 16'h0800, 16'd4, 16'h0, 3, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #7 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_done", {31'b0, done}, 32'h0);
        chk("midrst_addr", {16'b0, mem_addr}, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        chk("midrst_dst0", {16'b0, ram[16'h0800]}, 32'h00A1);
        chk("midrst_dst1", {16'b0, ram[16'h0801]}, 32'h7778);
        start_op(1'b1, 16'h0, 16'h0900, 16'd2, 16'h4242, -1, 1'b0);
        wait_done(3, "post_rst_done_cycle");
        @(negedge clk);
        chk("post_rst_fill", {16'b0, ram[16'h0901]}, 32'h4242);
        chk("post_rst_keep", {16'b0, ram[16'h0902]}, 32'h9002);

        // final sweep of every touched region against the reference memory
        for (int a = 16'h0100; a < 16'h0910; a++) begin
            if ((a < 16'h0104) || (a >= 16'h0200 && a < 16'h0204) ||
                (a >= 16'h0300 && a < 16'h0304) || (a >= 16'h0400 && a < 16'h0408) ||
                (a >= 16'h0500 && a < 16'h0508) || (a >= 16'h0600 && a < 16'h0604) ||
                (a == 16'h0700) || (a >= 16'h0800 && a < 16'h0802) ||
                (a >= 16'h0900 && a < 16'h0903))
                chk("ram_vs_model", {16'b0, ram[a]}, {16'b0, mram[a]});
        end
        chk("ram_vs_model_fffe", {16'b0, ram[16'hFFFE]}, {16'b0, mram[16'hFFFE]});

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
